// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-ported register file.
package regfile_pkg;

    localparam int DEFAULT_SIZE          = 32;
    localparam int DEFAULT_NUM_REGISTERS = 32;
    localparam int DEFAULT_NUM_READ      = 2;
    localparam int DEFAULT_NUM_WRITE     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/regfile_dbg_dump.sv
// Debug dump sequencer: walks register indices 0..NUM_REGISTERS-1 with valid/ready
// handshaking and pulses done once the last beat is accepted.
module regfile_dbg_dump
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_dbg_req,
    input  logic                             i_dbg_ready,
    output logic                             o_dbg_valid,
    output logic [$clog2(NUM_REGISTERS)-1:0] o_dbg_idx,
    output logic                             o_dbg_done
);

    localparam int AW = $clog2(NUM_REGISTERS);

    dbg_state_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            o_dbg_valid <= 1'b0;
            o_dbg_idx   <= '0;
            o_dbg_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_dbg_req) begin
                        state       <= DUMP;
                        o_dbg_valid <= 1'b1;
                        o_dbg_idx   <= '0;
                    end
                end
                DUMP: begin
                    if (i_dbg_ready) begin
                        if (o_dbg_idx == AW'(NUM_REGISTERS - 1)) begin
                            state       <= DONE;
                            o_dbg_valid <= 1'b0;
                            o_dbg_done  <= 1'b1;
                        end else begin
                            o_dbg_idx <= o_dbg_idx + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    o_dbg_done <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    o_dbg_valid <= 1'b0;
                    o_dbg_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with write bypass, pending-write scoreboard and an
// optional debug dump port enabled by defining REGFILE_MP_DEBUG_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int SIZE          = DEFAULT_SIZE,
    parameter int NUM_REGISTERS = DEFAULT_NUM_REGISTERS,
    parameter int NUM_READ      = DEFAULT_NUM_READ,
    parameter int NUM_WRITE     = DEFAULT_NUM_WRITE
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_WRITE-1:0]                       i_w_en,
    input  logic [NUM_WRITE*$clog2(NUM_REGISTERS)-1:0] i_w_dir,
    input  logic [NUM_WRITE*SIZE-1:0]                  i_w_data,
    input  logic [NUM_READ*$clog2(NUM_REGISTERS)-1:0]  i_r_dir,
    output logic [NUM_READ*SIZE-1:0]                   o_r_data,
    input  logic                                       i_busy_set,
    input  logic [$clog2(NUM_REGISTERS)-1:0]           i_busy_dir,
    output logic [NUM_READ-1:0]                        o_r_busy,
    output logic                                       o_stall
`ifdef REGFILE_MP_DEBUG_EN
    ,
    input  logic                                       i_dbg_req,
    input  logic                                       i_dbg_ready,
    output logic                                       o_dbg_valid,
    output logic [$clog2(NUM_REGISTERS)-1:0]           o_dbg_idx,
    output logic [SIZE-1:0]                            o_dbg_data,
    output logic                                       o_dbg_done
`endif
);

    localparam int AW = $clog2(NUM_REGISTERS);

    logic [SIZE-1:0]          regs   [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] pend;
    logic [NUM_REGISTERS-1:0] wr_hit;
    logic [SIZE-1:0]          wr_val [NUM_REGISTERS];
    logic [SIZE-1:0]          live   [NUM_REGISTERS];

    // Resolve this cycle's writes per register; later ports override earlier ones,
    // and "live" is what every reader sees including the same-cycle bypass.
    always_comb begin
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (r != 0 && i_w_en[k] && i_w_dir[k*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = i_w_data[k*SIZE +: SIZE];
                end
            end
            live[r] = wr_hit[r] ? wr_val[r] : regs[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // A new busy-set beats a same-cycle write because it names the next producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                if (r != 0 && i_busy_set && i_busy_dir == AW'(r)) begin
                    pend[r] <= 1'b1;
                end else if (wr_hit[r]) begin
                    pend[r] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_r_data <= '0;
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                o_r_data[p*SIZE +: SIZE] <= live[i_r_dir[p*AW +: AW]];
            end
        end
    end

    always_comb begin
        o_r_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            o_r_busy[p] = pend[i_r_dir[p*AW +: AW]] & ~wr_hit[i_r_dir[p*AW +: AW]];
        end
    end

    assign o_stall = |o_r_busy;

`ifdef REGFILE_MP_DEBUG_EN
    regfile_dbg_dump #(
        .NUM_REGISTERS(NUM_REGISTERS)
    ) u_dbg_dump (
        .clk        (clk),
        .rst        (rst),
        .i_dbg_req  (i_dbg_req),
        .i_dbg_ready(i_dbg_ready),
        .o_dbg_valid(o_dbg_valid),
        .o_dbg_idx  (o_dbg_idx),
        .o_dbg_done (o_dbg_done)
    );

    assign o_dbg_data = live[o_dbg_idx];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model;
// debug dump checks are included when REGFILE_MP_DEBUG_EN is defined.
module tb_regfile_mp;

    localparam int SIZE = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  w_en;
    logic [9:0]  w_dir;
    logic [63:0] w_data;
    logic [9:0]  r_dir;
    logic [63:0] r_data;
    logic        busy_set;
    logic [4:0]  busy_dir;
    logic [1:0]  r_busy;
    logic        stall;
`ifdef REGFILE_MP_DEBUG_EN
    logic        dbg_req;
    logic        dbg_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_idx;
    logic [31:0] dbg_data;
    logic        dbg_done;
`endif

    logic [31:0] mregs [NREG];
    logic        mpend [NREG];
    logic [31:0] mlive [NREG];
    int          checks = 0;
    int          failures = 0;
    bit          exp_active;
    bit          exp_done;
    int          exp_idx;
    int          seen_beats;
    int          seen_done;

    regfile_mp #(
        .SIZE         (SIZE),
        .NUM_REGISTERS(NREG),
        .NUM_READ     (NRD),
        .NUM_WRITE    (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_w_en    (w_en),
        .i_w_dir   (w_dir),
        .i_w_data  (w_data),
        .i_r_dir   (r_dir),
        .o_r_data  (r_data),
        .i_busy_set(busy_set),
        .i_busy_dir(busy_dir),
        .o_r_busy  (r_busy),
        .o_stall   (stall)
`ifdef REGFILE_MP_DEBUG_EN
        ,
        .i_dbg_req  (dbg_req),
        .i_dbg_ready(dbg_ready),
        .o_dbg_valid(dbg_valid),
        .o_dbg_idx  (dbg_idx),
        .o_dbg_data (dbg_data),
        .o_dbg_done (dbg_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Register contents as seen this cycle: committed state overlaid with writes in port order.
    task automatic computeLive();
        for (int r = 0; r < NREG; r++) mlive[r] = mregs[r];
        for (int k = 0; k < NWR; k++) begin
            if (w_en[k] && w_dir[k*AW +: AW] != 5'd0) mlive[w_dir[k*AW +: AW]] = w_data[k*SIZE +: SIZE];
        end
        mlive[0] = 32'h0;
    endtask

    task automatic clearModel();
        for (int r = 0; r < NREG; r++) begin
            mregs[r] = 32'h0;
            mpend[r] = 1'b0;
        end
        exp_active = 1'b0;
        exp_done   = 1'b0;
        exp_idx    = 0;
    endtask

    task automatic applyStimulus(input logic [1:0] en, input logic [9:0] wd, input logic [63:0] wdat,
                                 input logic [9:0] rd, input logic bs, input logic [4:0] bd);
        logic [1:0] eb;
        logic [4:0] a;
        logic       written;
        @(negedge clk);
        w_en = en; w_dir = wd; w_data = wdat; r_dir = rd; busy_set = bs; busy_dir = bd;
        #1;
        computeLive();
        for (int p = 0; p < NRD; p++) begin
            a = rd[p*AW +: AW];
            written = (en[0] && wd[4:0] == a) || (en[1] && wd[9:5] == a);
            eb[p] = mpend[a] && !written;
        end
        checkOutput("r_busy", 64'(r_busy), 64'(eb));
        checkOutput("stall", 64'(stall), 64'(|eb));
`ifdef REGFILE_MP_DEBUG_EN
        checkOutput("dbg_valid", 64'(dbg_valid), 64'(exp_active));
        if (exp_active) begin
            checkOutput("dbg_idx", 64'(dbg_idx), 64'(exp_idx));
            checkOutput("dbg_data", 64'(dbg_data), 64'(mlive[exp_idx]));
        end
        if (dbg_valid && dbg_ready) seen_beats++;
`endif
    endtask

    task automatic finishCycle();
        logic [63:0] exp_rd;
`ifdef REGFILE_MP_DEBUG_EN
        bit prev_done;
`endif
        exp_rd = {mlive[r_dir[9:5]], mlive[r_dir[4:0]]};
        @(posedge clk);
        #1;
        checkOutput("r_data", r_data, exp_rd);
        for (int r = 0; r < NREG; r++) mregs[r] = mlive[r];
        for (int k = 0; k < NWR; k++) begin
            if (w_en[k] && w_dir[k*AW +: AW] != 5'd0) mpend[w_dir[k*AW +: AW]] = 1'b0;
        end
        if (busy_set && busy_dir != 5'd0) mpend[busy_dir] = 1'b1;
`ifdef REGFILE_MP_DEBUG_EN
        prev_done = exp_done;
        exp_done  = 1'b0;
        if (exp_active) begin
            if (dbg_ready) begin
                if (exp_idx == NREG - 1) begin
                    exp_active = 1'b0;
                    exp_done   = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
        end else if (!prev_done && dbg_req) begin
            exp_active = 1'b1;
            exp_idx    = 0;
        end
        checkOutput("dbg_done", 64'(dbg_done), 64'(exp_done));
        if (dbg_done) seen_done++;
`endif
    endtask

    task automatic idleCycle();
        applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 1'b0, 5'd0);
        finishCycle();
    endtask

    function automatic logic [4:0] rndAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic randomCycle(input bit allow_busy);
        applyStimulus(2'($urandom_range(0, 3)), {rndAddr(), rndAddr()}, {$urandom, $urandom},
                      {rndAddr(), rndAddr()}, allow_busy && ($urandom_range(0, 3) == 0), rndAddr());
        finishCycle();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        w_en = 2'b00; busy_set = 1'b0;
`ifdef REGFILE_MP_DEBUG_EN
        dbg_req = 1'b0;
`endif
        #1;
        clearModel();
        checkOutput("rst_r_data", r_data, 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'd0);
`ifdef REGFILE_MP_DEBUG_EN
        checkOutput("rst_dbg_valid", 64'(dbg_valid), 64'd0);
        checkOutput("rst_dbg_done", 64'(dbg_done), 64'd0);
        checkOutput("rst_dbg_idx", 64'(dbg_idx), 64'd0);
`endif
        @(posedge clk);
        #1;
`ifdef REGFILE_MP_DEBUG_EN
        checkOutput("rst_dbg_done_hold", 64'(dbg_done), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        w_en = 2'b00; w_dir = 10'd0; w_data = 64'd0; r_dir = 10'd0; busy_set = 1'b0; busy_dir = 5'd0;
`ifdef REGFILE_MP_DEBUG_EN
        dbg_req = 1'b0; dbg_ready = 1'b0;
`endif
        seen_beats = 0; seen_done = 0;
        clearModel();
        doReset();

        applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 10'd0, 1'b0, 5'd0);
        finishCycle();
        applyStimulus(2'b00, 10'd0, 64'd0, {5'd5, 5'd0}, 1'b0, 5'd0);
        finishCycle();
        checkOutput("read_r5_port1", 64'(r_data[63:32]), 64'h DEADBEEF);

        applyStimulus(2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, {5'd0, 5'd7}, 1'b0, 5'd0);
        finishCycle();
        checkOutput("collide_bypass_r7", 64'(r_data[31:0]), 64'h22);
        applyStimulus(2'b00, 10'd0, 64'd0, {5'd0, 5'd7}, 1'b0, 5'd0);
        finishCycle();
        checkOutput("collide_hold_r7", 64'(r_data[31:0]), 64'h22);

        applyStimulus(2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 10'd0, 1'b1, 5'd0);
        finishCycle();
        checkOutput("r0_bypass_zero", r_data, 64'd0);
        applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 1'b0, 5'd0);
        checkOutput("r0_not_busy", 64'(r_busy), 64'd0);
        finishCycle();
        checkOutput("r0_read_zero", r_data, 64'd0);

        applyStimulus(2'b00, 10'd0, 64'd0, {5'd0, 5'd3}, 1'b1, 5'd3);
        checkOutput("r3_not_yet_pending", 64'(stall), 64'd0);
        finishCycle();
        checkOutput("r3_pending_stall", 64'(stall), 64'd1);
        applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h5}, {5'd0, 5'd3}, 1'b0, 5'd0);
        checkOutput("r3_write_clears_stall", 64'(stall), 64'd0);
        finishCycle();
        checkOutput("r3_write_data", 64'(r_data[31:0]), 64'h5);
        applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h9}, {5'd0, 5'd3}, 1'b1, 5'd3);
        finishCycle();
        applyStimulus(2'b00, 10'd0, 64'd0, {5'd0, 5'd3}, 1'b0, 5'd0);
        checkOutput("r3_set_wins", 64'(stall), 64'd1);
        finishCycle();

        for (int i = 0; i < 400; i++) begin
`ifdef REGFILE_MP_DEBUG_EN
            dbg_req   = ($urandom_range(0, 15) == 0);
            dbg_ready = 1'($urandom_range(0, 1));
`endif
            randomCycle(1'b1);
        end

`ifdef REGFILE_MP_DEBUG_EN
        dbg_req = 1'b0;
        dbg_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_active || exp_done); i++) idleCycle();

        // Dump with ready toggling while writes keep landing, exercising the live bypass.
        seen_beats = 0; seen_done = 0;
        dbg_req = 1'b1; dbg_ready = 1'b0;
        idleCycle();
        dbg_req = 1'b0;
        for (int c = 0; c < 80; c++) begin
            dbg_ready = (c % 2 == 1);
            randomCycle(1'b0);
        end
        checkOutput("dump_beats", 64'(seen_beats), 64'd32);
        checkOutput("dump_done_pulses", 64'(seen_done), 64'd1);

        dbg_req = 1'b1; dbg_ready = 1'b1;
        idleCycle();
        dbg_req = 1'b0;
        for (int c = 0; c < 40 && exp_idx != 10; c++) randomCycle(1'b0);
        seen_done = 0;
`else
        for (int c = 0; c < 10; c++) randomCycle(1'b0);
`endif
        doReset();
        for (int a = 0; a < NREG / 2; a++) begin
            applyStimulus(2'b00, 10'd0, 64'd0, {5'(2*a+1), 5'(2*a)}, 1'b0, 5'd0);
            finishCycle();
            checkOutput("post_reset_zero", r_data, 64'd0);
        end
`ifdef REGFILE_MP_DEBUG_EN
        checkOutput("abort_no_done", 64'(seen_done), 64'd0);
        dbg_req = 1'b1; dbg_ready = 1'b0;
        idleCycle();
        dbg_req = 1'b0;
        applyStimulus(2'b00, 10'd0, 64'd0, 10'd0, 1'b0, 5'd0);
        checkOutput("restart_valid", 64'(dbg_valid), 64'd1);
        checkOutput("restart_idx", 64'(dbg_idx), 64'd0);
        finishCycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter SIZE, default 32, data width in bits.
REQ-002 SHALL have parameter NUM_REGISTERS, default 32, register count (power of two, >=4).
REQ-003 SHALL have parameter NUM_READ, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WRITE, default 2, number of write ports (1..2).
REQ-005 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have i_w_en  in  NUM_WRITE  per-port write enable.
REQ-008 SHALL have i_w_dir  in  NUM_WRITE*log2(NUM_REGISTERS)  packed write addresses.
REQ-009 SHALL have i_w_data  in  NUM_WRITE*SIZE  packed write data.
REQ-010 SHALL have i_r_dir  in  NUM_READ*log2(NUM_REGISTERS)  packed read addresses.
REQ-011 SHALL have o_r_data  out  NUM_READ*SIZE  packed registered read data.
REQ-012 SHALL have i_busy_set, i_busy_dir  in  1, log2(NUM_REGISTERS)  scoreboard mark-pending.
REQ-013 SHALL have o_r_busy  out  NUM_READ  per-read-port pending flag; o_stall  out  1  OR of o_r_busy.
REQ-014 SHALL have, under REGFILE_MP_DEBUG_EN, i_dbg_req in 1, i_dbg_ready in 1, o_dbg_valid out 1, o_dbg_idx out log2(NUM_REGISTERS), o_dbg_data out SIZE, o_dbg_done out 1.

Function
REQ-015 Register 0 SHALL read as zero always; writes and busy-sets to address 0 SHALL be ignored.
REQ-016 A write with i_w_en[k]=1 SHALL update the addressed register at the rising edge.
REQ-017 Two write ports to the same nonzero address in one cycle: higher port index SHALL win.
REQ-018 o_r_data SHALL have 1-cycle latency: value captured at edge N reflects i_r_dir sampled at edge N.
REQ-019 Same-cycle write to a read address SHALL be bypassed: captured read data equals the winning write data.
REQ-020 Scoreboard: i_busy_set SHALL mark i_busy_dir pending at the edge; any write to a register SHALL clear its pending bit.
REQ-021 Set and write-clear of the same register in one cycle: set SHALL win (new pending producer).
REQ-022 o_r_busy[p] SHALL be combinational: pending bit of i_r_dir[p] AND NOT (a write to that address this cycle); o_stall = OR of o_r_busy.
REQ-023 Debug dump FSM SHALL have states IDLE, DUMP, DONE; IDLE->DUMP on i_dbg_req; i_dbg_req outside IDLE ignored.
REQ-024 In DUMP, o_dbg_valid=1 with o_dbg_idx from 0 to NUM_REGISTERS-1; index advances only when o_dbg_valid && i_dbg_ready.
REQ-025 o_dbg_data SHALL be the live content of register o_dbg_idx, including same-cycle bypass.
REQ-026 After the beat at index NUM_REGISTERS-1 is accepted, FSM SHALL go to DONE, pulse o_dbg_done for one cycle, then return to IDLE.

Reset
REQ-027 On rst low, all registers, pending bits, o_r_data, o_dbg_idx SHALL be 0; FSM IDLE; o_dbg_valid, o_dbg_done 0.
REQ-028 Reset asserted mid-dump SHALL abort immediately with no o_dbg_done pulse.

Configuration
REQ-029 Macro REGFILE_MP_DEBUG_EN defined: debug ports and dump FSM present per REQ-014/023-026.
REQ-030 Macro undefined: debug ports and FSM absent; all other behaviour identical.

Structure
REQ-031 Package regfile_pkg SHALL hold dump FSM state typedef (IDLE/DUMP/DONE) and default-width constants.
REQ-032 Dump FSM SHALL be sub-module regfile_dbg_dump; storage, bypass and scoreboard stay in regfile_mp.

Verification
REQ-033 Write r5=0xDEADBEEF via port 0, read r5 next cycle on port 1 -> o_r_data[1]=0xDEADBEEF one cycle after address presented.
REQ-034 Port 0 writes r7=0x11, port 1 writes r7=0x22, same cycle, read r7 same cycle -> captured 0x22 and r7 holds 0x22.
REQ-035 Write r0=0xFFFFFFFF, busy-set r0 -> r0 reads 0, o_r_busy=0.
REQ-036 busy-set r3, read r3 -> o_stall=1; write r3=0x5 -> o_stall=0 that cycle; set+write r3 same cycle -> r3 remains pending.
REQ-037 Dump with i_dbg_ready toggling every other cycle -> 32 accepted beats, indices 0..31, values match, one o_dbg_done pulse.
REQ-038 Reset at dump index 10 -> o_dbg_valid=0, no o_dbg_done, all registers 0, new i_dbg_req restarts at index 0.
